// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package instr_mem_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned COUNT_W        = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Little-endian byte-to-word assembler: first byte lands in [7:0], fourth in [31:24].
module byte_word_packer
    import instr_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              last_byte
);

    logic [IDX_W-1:0] idx;

    // Shift each accepted byte in from the top; the index wraps after the last byte of a word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (accept) begin
            word <= {byte_in, word[WORD_W-1:BYTE_W]};
            idx  <= idx + IDX_W'(1);
        end
    end

    assign last_byte = (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Streams program bytes into instruction memory while holding the CPU in reset.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 18,
    parameter logic [31:0] BASE_ADDR = 32'h0
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] word_count,
    input  logic               abort,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               wr_en,
    output logic [WORD_W-1:0]  wr_addr,
    output logic [WORD_W-1:0]  wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    localparam logic [WORD_W-1:0] MAX_WORDS = WORD_W'(MEM_WORDS);
    localparam logic [WORD_W-1:0] ADDR_INC  = WORD_W'(BYTES_PER_WORD);

    state_t             state;
    logic [WORD_W-1:0]  addr;
    logic [COUNT_W-1:0] remaining;
    logic               wr_pending;
    logic               accept;
    logic               last_byte;
    logic [WORD_W-1:0]  word;

    // A byte is taken only while ready; an abort in the same cycle discards it.
    assign accept  = byte_valid && byte_ready && !abort;
    // Abort during the write cycle must kill the strobe in that same cycle.
    assign wr_en   = wr_pending && !abort;
    assign wr_data = word;

    // Packer index is held at zero whenever idle, so aborted partial words vanish.
    byte_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .accept    (accept),
        .byte_in   (byte_in),
        .word      (word),
        .last_byte (last_byte)
    );

    // Load sequencer with address/count tracking; outputs follow the state they enter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= BASE_ADDR;
            remaining  <= '0;
            byte_ready <= 1'b0;
            wr_pending <= 1'b0;
            wr_addr    <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_pending <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cpu_hold <= 1'b1;
                        if (word_count == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (WORD_W'(word_count) > MAX_WORDS) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err        <= 1'b0;
                            remaining  <= word_count;
                            addr       <= BASE_ADDR;
                            byte_ready <= 1'b1;
                            state      <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (abort) begin
                        err        <= 1'b1;
                        byte_ready <= 1'b0;
                        cpu_hold   <= 1'b0;
                        state      <= IDLE;
                    end else if (accept && last_byte) begin
                        byte_ready <= 1'b0;
                        wr_pending <= 1'b1;
                        wr_addr    <= addr;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        err      <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        addr      <= addr + ADDR_INC;
                        remaining <= remaining - COUNT_W'(1);
                        if (remaining == COUNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            byte_ready <= 1'b1;
                            state      <= RECV;
                        end
                    end
                end
                DONE: begin
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
